// File: rtl/pixel_scan_fsm.sv
// Pixel-array scan sequencer: walks rows/columns, settles, keys, converts, stores.
// Optional macro PIXEL_SCAN_TIMEOUT_EN adds a 256-cycle conversion timeout (stores 12'hFFF).
module pixel_scan_fsm #(
  parameter int N_ROWS        = 24,
  parameter int N_COLS        = 24,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        i_go,
  input  logic        i_adc_valid,
  input  logic [11:0] i_adc_data,
  output logic [4:0]  o_row_control,
  output logic [4:0]  o_col_control,
  output logic        o_row_reg_data,
  output logic        o_row_reg_write,
  output logic        o_col_reg_data,
  output logic        o_col_reg_write,
  output logic        o_key_wren,
  output logic        o_adc_start,
  output logic        o_ram_wren,
  output logic [11:0] o_ram_data,
  output logic        o_scan_end
);

  localparam int DATA_W = 12;
  localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int COL_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  localparam logic [4:0] CTL_CLEAR = 5'b10000;
  localparam logic [4:0] CTL_INC   = 5'b00001;
  localparam logic [4:0] CTL_HOLD  = 5'b00000;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ROW_LOAD = 3'd1;
  localparam logic [2:0] S_COL_LOAD = 3'd2;
  localparam logic [2:0] S_SETTLE   = 3'd3;
  localparam logic [2:0] S_KEY      = 3'd4;
  localparam logic [2:0] S_CONV     = 3'd5;
  localparam logic [2:0] S_STORE    = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]        state_p0;
  logic [ROW_W-1:0]  row_p0;
  logic [COL_W-1:0]  col_p0;
  logic [SET_W-1:0]  settle_p0;
  logic              adc_started_p0;
  logic [DATA_W-1:0] data_p0;
`ifdef PIXEL_SCAN_TIMEOUT_EN
  logic [7:0]        conv_cnt_p0;
`endif

  // State, indices and the latched conversion result all advance only when en is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0       <= S_IDLE;
      row_p0         <= '0;
      col_p0         <= '0;
      settle_p0      <= '0;
      adc_started_p0 <= 1'b0;
      data_p0        <= '0;
`ifdef PIXEL_SCAN_TIMEOUT_EN
      conv_cnt_p0    <= '0;
`endif
    end else if (en) begin
      if (state_p0 != S_IDLE && !i_go) begin
        state_p0       <= S_IDLE;
        settle_p0      <= '0;
        adc_started_p0 <= 1'b0;
      end else begin
        case (state_p0)
          S_IDLE: begin
            row_p0 <= '0;
            col_p0 <= '0;
            if (i_go) state_p0 <= S_ROW_LOAD;
          end
          S_ROW_LOAD: begin
            col_p0   <= '0;
            state_p0 <= S_COL_LOAD;
          end
          S_COL_LOAD: begin
            settle_p0 <= '0;
            state_p0  <= S_SETTLE;
          end
          S_SETTLE: begin
            if (settle_p0 == SET_LAST) begin
              settle_p0 <= '0;
              state_p0  <= S_KEY;
            end else begin
              settle_p0 <= settle_p0 + SET_W'(1);
            end
          end
          S_KEY: begin
            adc_started_p0 <= 1'b0;
`ifdef PIXEL_SCAN_TIMEOUT_EN
            conv_cnt_p0    <= '0;
`endif
            state_p0       <= S_CONV;
          end
          S_CONV: begin
            // adc_started_p0 marks every CONV cycle after the first, so the start pulse is single.
            adc_started_p0 <= 1'b1;
            if (i_adc_valid) begin
              data_p0  <= i_adc_data;
              state_p0 <= S_STORE;
            end
`ifdef PIXEL_SCAN_TIMEOUT_EN
            else if (conv_cnt_p0 == 8'hFF) begin
              data_p0  <= 12'hFFF;
              state_p0 <= S_STORE;
            end else begin
              conv_cnt_p0 <= conv_cnt_p0 + 8'd1;
            end
`endif
          end
          S_STORE: begin
            adc_started_p0 <= 1'b0;
            if (col_p0 != COL_LAST) begin
              col_p0   <= col_p0 + COL_W'(1);
              state_p0 <= S_COL_LOAD;
            end else if (row_p0 != ROW_LAST) begin
              col_p0   <= '0;
              row_p0   <= row_p0 + ROW_W'(1);
              state_p0 <= S_ROW_LOAD;
            end else begin
              state_p0 <= S_DONE;
            end
          end
          S_DONE:  state_p0 <= S_IDLE;
          default: state_p0 <= S_IDLE;
        endcase
      end
    end
  end

  // Moore output decode from registered state and indices.
  always_comb begin
    o_row_control   = CTL_HOLD;
    o_col_control   = CTL_HOLD;
    o_row_reg_data  = 1'b0;
    o_row_reg_write = 1'b0;
    o_col_reg_data  = 1'b0;
    o_col_reg_write = 1'b0;
    o_key_wren      = 1'b0;
    o_adc_start     = 1'b0;
    o_ram_wren      = 1'b0;
    o_ram_data      = '0;
    o_scan_end      = 1'b0;
    case (state_p0)
      S_IDLE: begin
        o_row_control = CTL_CLEAR;
        o_col_control = CTL_CLEAR;
      end
      S_ROW_LOAD: begin
        o_row_reg_write = 1'b1;
        o_row_reg_data  = (row_p0 == '0);
      end
      S_COL_LOAD: begin
        o_col_reg_write = 1'b1;
        o_col_reg_data  = (col_p0 == '0);
      end
      S_KEY:  o_key_wren  = 1'b1;
      S_CONV: o_adc_start = !adc_started_p0;
      S_STORE: begin
        o_ram_wren = 1'b1;
        o_ram_data = data_p0;
        if (col_p0 == COL_LAST) begin
          o_col_control = CTL_CLEAR;
          o_row_control = CTL_INC;
        end else begin
          o_col_control = CTL_INC;
        end
      end
      S_DONE:  o_scan_end = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pixel_scan_fsm.sv
// Directed, table-driven bench for pixel_scan_fsm on a 2x3 array with a 2-cycle settle.
module tb_pixel_scan_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        i_go = 1'b0;
  logic        i_adc_valid = 1'b0;
  logic [11:0] i_adc_data = '0;
  logic [4:0]  o_row_control, o_col_control;
  logic        o_row_reg_data, o_row_reg_write, o_col_reg_data, o_col_reg_write;
  logic        o_key_wren, o_adc_start, o_ram_wren, o_scan_end;
  logic [11:0] o_ram_data;

  pixel_scan_fsm #(.N_ROWS(2), .N_COLS(3), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .i_go(i_go),
    .i_adc_valid(i_adc_valid), .i_adc_data(i_adc_data),
    .o_row_control(o_row_control), .o_col_control(o_col_control),
    .o_row_reg_data(o_row_reg_data), .o_row_reg_write(o_row_reg_write),
    .o_col_reg_data(o_col_reg_data), .o_col_reg_write(o_col_reg_write),
    .o_key_wren(o_key_wren), .o_adc_start(o_adc_start),
    .o_ram_wren(o_ram_wren), .o_ram_data(o_ram_data), .o_scan_end(o_scan_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] exp_ram;
    logic [4:0]  exp_col_ctl;
    logic [4:0]  exp_row_ctl;
    logic        exp_col_data;
  } pix_vec_t;

  pix_vec_t vec [6];
  logic     row_exp [2];

  int n_chk = 0;
  int n_fail = 0;

  // ADC model: answers 12'h100 + pixel index two cycles after each start pulse.
  bit adc_auto = 1'b1;
  int adc_cnt = 0;
  int adc_pix = 0;
  always @(negedge clk) begin
    if (rst) begin
      adc_cnt = 0;
      adc_pix = 0;
      i_adc_valid = 1'b0;
    end else begin
      if (i_adc_valid) i_adc_valid = 1'b0;
      if (adc_cnt > 0) begin
        adc_cnt--;
        if (adc_cnt == 0) begin
          i_adc_valid = 1'b1;
          i_adc_data  = 12'h100 + 12'(adc_pix);
          adc_pix++;
        end
      end
      if (o_adc_start && adc_auto) adc_cnt = 2;
    end
  end

  // Event log of every strobe seen.
  logic [11:0] ram_log [64];
  logic [4:0]  colctl_log [64];
  logic [4:0]  rowctl_log [64];
  logic        row_log [64];
  logic        col_log [64];
  int ram_n = 0, row_n = 0, col_n = 0, key_n = 0, end_n = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (o_ram_wren && ram_n < 64) begin
        ram_log[ram_n]    = o_ram_data;
        colctl_log[ram_n] = o_col_control;
        rowctl_log[ram_n] = o_row_control;
        ram_n++;
      end
      if (o_row_reg_write && row_n < 64) begin
        row_log[row_n] = o_row_reg_data;
        row_n++;
      end
      if (o_col_reg_write && col_n < 64) begin
        col_log[col_n] = o_col_reg_data;
        col_n++;
      end
      if (o_key_wren) key_n++;
      if (o_scan_end) end_n++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_row_ctl"}, 32'(o_row_control), 32'h10);
    check({tag, "_col_ctl"}, 32'(o_col_control), 32'h10);
    check({tag, "_strobes"}, 32'({o_row_reg_write, o_col_reg_write, o_key_wren,
                                  o_adc_start, o_ram_wren, o_scan_end}), 32'h0);
    check({tag, "_ram_data"}, 32'(o_ram_data), 32'h0);
  endtask

  // Waits on negedges for the nth pulse: 0 col_reg_write, 1 adc_start, 2 scan_end, 3 ram_wren.
  task automatic wait_pulse(input int sel, input int nth, input int budget, output bit ok);
    int seen = 0;
    logic s;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (sel)
        0: s = o_col_reg_write;
        1: s = o_adc_start;
        2: s = o_scan_end;
        default: s = o_ram_wren;
      endcase
      if (s) seen++;
      if (seen == nth) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic reset_dut();
    i_go = 1'b0;
    en   = 1'b1;
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    int b_ram, b_row, b_col, b_key, b_end;
    int first;
    logic [11:0] tdata;

    vec[0] = '{12'h100, 5'b00001, 5'b00000, 1'b1};
    vec[1] = '{12'h101, 5'b00001, 5'b00000, 1'b0};
    vec[2] = '{12'h102, 5'b10000, 5'b00001, 1'b0};
    vec[3] = '{12'h103, 5'b00001, 5'b00000, 1'b1};
    vec[4] = '{12'h104, 5'b00001, 5'b00000, 1'b0};
    vec[5] = '{12'h105, 5'b10000, 5'b00001, 1'b0};
    row_exp[0] = 1'b1;
    row_exp[1] = 1'b0;

    // Reset state, and no start without i_go.
    #1 check_idle("reset");
    reset_dut();
    repeat (4) @(negedge clk);
    check_idle("idle_no_go");

    // Full scan.
    b_ram = ram_n; b_row = row_n; b_col = col_n; b_key = key_n; b_end = end_n;
    i_go = 1'b1;
    wait_pulse(2, 1, 400, ok);
    i_go = 1'b0;
    check("scan_end_seen", 32'(ok), 32'h1);
    @(negedge clk);
    check_idle("after_scan");
    repeat (3) @(negedge clk);
    check("ram_wren_count", 32'(ram_n - b_ram), 32'd6);
    check("row_write_count", 32'(row_n - b_row), 32'd2);
    check("col_write_count", 32'(col_n - b_col), 32'd6);
    check("key_count", 32'(key_n - b_key), 32'd6);
    check("scan_end_count", 32'(end_n - b_end), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("ram_data[%0d]", i), 32'(ram_log[b_ram + i]), 32'(vec[i].exp_ram));
      check($sformatf("store_col_ctl[%0d]", i), 32'(colctl_log[b_ram + i]), 32'(vec[i].exp_col_ctl));
      check($sformatf("store_row_ctl[%0d]", i), 32'(rowctl_log[b_ram + i]), 32'(vec[i].exp_row_ctl));
      check($sformatf("col_reg_data[%0d]", i), 32'(col_log[b_col + i]), 32'(vec[i].exp_col_data));
    end
    for (int i = 0; i < 2; i++)
      check($sformatf("row_reg_data[%0d]", i), 32'(row_log[b_row + i]), 32'(row_exp[i]));

    // Abort during the third pixel's settle.
    reset_dut();
    b_ram = ram_n; b_key = key_n; b_end = end_n;
    i_go = 1'b1;
    wait_pulse(0, 3, 200, ok);
    check("abort_reach_col3", 32'(ok), 32'h1);
    @(negedge clk);
    i_go = 1'b0;
    @(negedge clk);
    check("abort_row_ctl", 32'(o_row_control), 32'h10);
    check("abort_col_ctl", 32'(o_col_control), 32'h10);
    repeat (30) @(negedge clk);
    check("abort_ram_count", 32'(ram_n - b_ram), 32'd2);
    check("abort_key_count", 32'(key_n - b_key), 32'd2);
    check("abort_end_count", 32'(end_n - b_end), 32'd0);

    // Clock-enable freeze in SETTLE.
    reset_dut();
    i_go = 1'b1;
    wait_pulse(0, 1, 50, ok);
    check("en_reach_col", 32'(ok), 32'h1);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("frozen_strobes[%0d]", i),
            32'({o_key_wren, o_col_reg_write, o_row_control, o_col_control}), 32'h0);
    end
    en = 1'b1;
    @(negedge clk);
    check("en_settle_last", 32'(o_key_wren), 32'h0);
    @(negedge clk);
    check("en_key_timing", 32'(o_key_wren), 32'h1);
    wait_pulse(3, 1, 20, ok);
    check("en_store_seen", 32'(ok), 32'h1);
    check("en_store_data", 32'(o_ram_data), 32'h100);
    i_go = 1'b0;

    // Asynchronous reset during CONV, then restart from row 0 col 0.
    reset_dut();
    i_go = 1'b1;
    wait_pulse(1, 1, 50, ok);
    check("rst_reach_conv", 32'(ok), 32'h1);
    rst = 1'b1;
    #1 check_idle("rst_in_conv");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_row_write", 32'({o_row_reg_write, o_row_reg_data}), 32'h3);
    @(negedge clk);
    check("restart_col_write", 32'({o_col_reg_write, o_col_reg_data}), 32'h3);
    wait_pulse(3, 1, 20, ok);
    check("restart_store_seen", 32'(ok), 32'h1);
    check("restart_store_data", 32'(o_ram_data), 32'h100);
    i_go = 1'b0;

    // ADC never answers.
    reset_dut();
    adc_auto = 1'b0;
    i_go = 1'b1;
    wait_pulse(1, 1, 50, ok);
    check("noadc_reach_conv", 32'(ok), 32'h1);
    first = 0;
    tdata = '0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (o_ram_wren && first == 0) begin
        first = i;
        tdata = o_ram_data;
      end
    end
`ifdef PIXEL_SCAN_TIMEOUT_EN
    check("timeout_store_cycle", 32'(first), 32'd256);
    check("timeout_store_data", 32'(tdata), 32'hFFF);
`else
    check("no_timeout_store", 32'(first), 32'd0);
    check("no_timeout_data", 32'(tdata), 32'h0);
`endif
    i_go = 1'b0;
    adc_auto = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_scan_fsm.md
PIXEL_SCAN_FSM -- requirements
Module: pixel_scan_fsm

Interface
REQ-001 Parameters SHALL be: N_ROWS, 24, rows scanned; N_COLS, 24, columns per row; SETTLE_CYCLES, 4, settle wait per pixel (>=1).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  clock enable; when 0, all registers hold.
REQ-005 i_go  input  1  scan grant from top-level sequencer; level, held high for the whole scan.
REQ-006 i_adc_valid  input  1  single-cycle pulse, conversion result ready; i_adc_data  input  12  conversion result.
REQ-007 o_row_control, o_col_control  output  5 each  counter command: 5'b10000 clear, 5'b00001 increment, 5'b00000 hold.
REQ-008 o_row_reg_data, o_row_reg_write, o_col_reg_data, o_col_reg_write  output  1 each  chip shift-register data and write strobes.
REQ-009 o_key_wren  output  1  pixel key write strobe; o_adc_start  output  1  conversion start pulse.
REQ-010 o_ram_wren  output  1  RAM write strobe; o_ram_data  output  12  pixel value to RAM.
REQ-011 o_scan_end  output  1  single-cycle end-of-scan pulse.

Function
REQ-012 States SHALL be IDLE, ROW_LOAD, COL_LOAD, SETTLE, KEY, CONV, STORE, DONE; all outputs registered-state decoded (Moore).
REQ-013 IDLE: row/col control = clear, all strobes 0, o_ram_data 0; i_go=1 -> ROW_LOAD with row=0, col=0.
REQ-014 ROW_LOAD (1 cycle): o_row_reg_write=1, o_row_reg_data=(row==0); col index cleared; -> COL_LOAD.
REQ-015 COL_LOAD (1 cycle): o_col_reg_write=1, o_col_reg_data=(col==0); -> SETTLE.
REQ-016 SETTLE: exactly SETTLE_CYCLES cycles, strobes 0; -> KEY.
REQ-017 KEY (1 cycle): o_key_wren=1; -> CONV.
REQ-018 CONV: o_adc_start=1 on first CONV cycle only; i_adc_data latched on cycle i_adc_valid=1; -> STORE next cycle; valid sampled only in CONV.
REQ-019 STORE (1 cycle): o_ram_wren=1, o_ram_data=latched value; col_control=increment.
REQ-020 STORE, col<N_COLS-1: col+1 -> COL_LOAD.
REQ-021 STORE, col==N_COLS-1, row<N_ROWS-1: col_control=clear, row_control=increment, row+1 -> ROW_LOAD.
REQ-022 STORE, last pixel: col_control=clear, row_control=increment -> DONE.
REQ-023 DONE (1 cycle): o_scan_end=1; -> IDLE unconditionally; new scan needs i_go high in IDLE.
REQ-024 i_go=0 in any non-IDLE state SHALL abort to IDLE next enabled edge; no o_ram_wren or o_scan_end in the abort cycle.
REQ-025 Row/col indices SHALL be $clog2 width, never exceed N-1, no wrap beyond last pixel.
REQ-026 Outside states named above, every strobe SHALL be 0 and counter controls hold (5'b00000).

Reset
REQ-027 rst=1 SHALL force IDLE, indices 0, SETTLE counter 0, latched data 0, outputs at IDLE values, asynchronously, including mid-scan.
REQ-028 After rst release, first scan SHALL begin only on i_go=1 sampled in IDLE.

Configuration
REQ-029 Macro PIXEL_SCAN_TIMEOUT_EN defined: CONV SHALL count cycles; 256 cycles without i_adc_valid -> latch 12'hFFF, -> STORE, scan continues.
REQ-030 Macro undefined: CONV SHALL wait indefinitely for i_adc_valid; no timeout logic present.

Verification
REQ-031 N_ROWS=2, N_COLS=3, SETTLE=2, i_go held, ADC returns 12'h100+pixel index 2 cycles after start -> six o_ram_wren pulses, data 0x100..0x105 in order, one o_scan_end, FSM in IDLE.
REQ-032 Same config -> o_row_reg_write pulses=2 (data 1 then 0), o_col_reg_write pulses=6 (data 1,0,0,1,0,0), o_key_wren pulses=6.
REQ-033 Drop i_go during third SETTLE -> IDLE next cycle, counter controls = 5'b10000, no further wren, no o_scan_end.
REQ-034 Assert rst during CONV -> all outputs IDLE values immediately; later i_go restarts at row 0 col 0.
REQ-035 en=0 for 5 cycles in SETTLE -> state and outputs frozen, per-pixel timing otherwise unchanged.
REQ-036 PIXEL_SCAN_TIMEOUT_EN defined, i_adc_valid never asserted -> STORE 256 cycles after CONV entry with o_ram_data=12'hFFF; undefined -> stays in CONV.
